// File: rtl/epd_pkg.sv
// epd_pkg: shared types and constants for the exhaustive pattern driver
package epd_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, EMIT, DONE} state_t;
    localparam int DEF_N_WIDTH = 5;
    localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
    localparam logic [DEF_N_WIDTH-1:0] LAST_PATTERN = '1;
endpackage

// File: rtl/resp_misr.sv
// resp_misr: Galois-form MISR compacting one response word per enable
module resp_misr
    import epd_pkg::*;
#(
    parameter int SIG_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY = SIG_WIDTH'(DEF_SIG_POLY),
    parameter int OUT_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [OUT_WIDTH-1:0] data,
    output logic [SIG_WIDTH-1:0] signature
);
    logic [SIG_WIDTH-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = clear  ? '0 :
                enable ? ({sig_q[SIG_WIDTH-2:0], 1'b0} ^ (sig_q[SIG_WIDTH-1] ? SIG_POLY : '0)
                          ^ SIG_WIDTH'(data)) :
                         sig_q;
    end

    always_ff @(posedge clk) begin
        if (rst) sig_q <= '0;
        else     sig_q <= sig_d;
    end

    assign signature = sig_q;
endmodule

// File: rtl/exhaustive_pattern_driver.sv
// exhaustive_pattern_driver: sweeps every input pattern, samples the DUT after a settle
// time and streams (pattern, response) records while compacting them into a MISR
module exhaustive_pattern_driver
    import epd_pkg::*;
#(
    parameter int N_WIDTH = DEF_N_WIDTH,
    parameter int OUT_WIDTH = 1,
    parameter int SETTLE_CYCLES = 1,
    parameter int SIG_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY = SIG_WIDTH'(DEF_SIG_POLY)
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_WIDTH-1:0]   pattern,
    input  logic [OUT_WIDTH-1:0] dut_resp,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [N_WIDTH-1:0]   resp_pattern,
    output logic [OUT_WIDTH-1:0] resp_bits,
    output logic                 busy,
    output logic                 done,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [N_WIDTH:0]     ones_count
);
    localparam logic [N_WIDTH-1:0] LAST = '1;
    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t               state_q, state_d;
    logic [N_WIDTH-1:0]   pattern_q, pattern_d, rpat_q, rpat_d;
    logic [OUT_WIDTH-1:0] rbits_q, rbits_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [N_WIDTH:0]     ones_q, ones_d;
    logic                 clear, sample;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        rpat_d    = rpat_q;
        rbits_d   = rbits_q;
        cnt_d     = cnt_q;
        ones_d    = ones_q;
        clear     = 1'b0;
        sample    = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d   = SETTLE;
                pattern_d = '0;
                cnt_d     = RELOAD;
                ones_d    = '0;
                clear     = 1'b1;
            end
            SETTLE: if (cnt_q == 8'd0) begin
                state_d = EMIT;
                sample  = 1'b1;
                rbits_d = dut_resp;
                rpat_d  = pattern_q;
                ones_d  = ones_q + (N_WIDTH+1)'(dut_resp[0]);
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            EMIT: if (resp_ready) begin
                state_d   = (pattern_q == LAST) ? DONE : SETTLE;
                pattern_d = (pattern_q == LAST) ? pattern_q : pattern_q + 1'b1;
                cnt_d     = RELOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            rpat_q    <= '0;
            rbits_q   <= '0;
            cnt_q     <= '0;
            ones_q    <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            rpat_q    <= rpat_d;
            rbits_q   <= rbits_d;
            cnt_q     <= cnt_d;
            ones_q    <= ones_d;
        end
    end

    resp_misr #(
        .SIG_WIDTH(SIG_WIDTH),
        .SIG_POLY (SIG_POLY),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_misr (
        .clk      (CK),
        .rst      (reset),
        .clear    (clear),
        .enable   (sample),
        .data     (dut_resp),
        .signature(signature)
    );

    assign pattern      = pattern_q;
    assign resp_pattern = rpat_q;
    assign resp_bits    = rbits_q;
    assign ones_count   = ones_q;
    assign resp_valid   = (state_q == EMIT);
    assign busy         = (state_q == SETTLE) || (state_q == EMIT);
    assign done         = (state_q == DONE);
endmodule

// File: tb/tb_exhaustive_pattern_driver.sv
// tb_exhaustive_pattern_driver: scoreboard bench for the pattern sweep driver
module tb_exhaustive_pattern_driver;
    logic        CK = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  pattern;
    logic [0:0]  dut_resp;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [4:0]  resp_pattern;
    logic [0:0]  resp_bits;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [5:0]  ones_count;

    int mode = 0;
    int passed = 0;
    int total = 0;
    logic [5:0] exp_q[$];

    always #5 CK = ~CK;

    // 0: loopback of pattern[0], 1: tied low, 2: high only on the last pattern
    assign dut_resp = (mode == 0) ? pattern[0] : (mode == 2) ? (pattern == 5'd31) : 1'b0;

    exhaustive_pattern_driver dut (
        .CK(CK), .reset(reset), .start(start), .pattern(pattern), .dut_resp(dut_resp),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pattern(resp_pattern),
        .resp_bits(resp_bits), .busy(busy), .done(done), .signature(signature),
        .ones_count(ones_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic resp_of(input int m, input int p);
        return (m == 0) ? p[0] : (m == 2) ? (p == 31) : 1'b0;
    endfunction

    function automatic logic [15:0] misr_of(input int m);
        logic [15:0] s = 16'h0;
        for (int p = 0; p < 32; p++)
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {15'h0, resp_of(m, p)};
        return s;
    endfunction

    // Sampled just before the next rising edge so it sees the ready value that edge will use
    always @(negedge CK) begin
        #3;
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) chk("unexpected_record", {26'h0, resp_bits, resp_pattern}, 32'hffff);
            else chk("record", {26'h0, resp_bits, resp_pattern}, {26'h0, exp_q.pop_front()});
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CK);
        #1 start = 1'b0;
    endtask

    task automatic sweep(input int m, input bit bp, input bit mid_start,
                         input logic [15:0] exp_sig, input int exp_ones);
        int cyc = 0;
        int hold = 0;
        bit bp_done = 0;
        mode = m;
        for (int p = 0; p < 32; p++) exp_q.push_back({resp_of(m, p), 5'(p)});
        pulse_start();
        chk("start_state", {done, busy, pattern, ones_count, signature},
            {1'b0, 1'b1, 5'd0, 6'd0, 16'h0});
        while (!done && cyc < 500) begin
            @(posedge CK);
            cyc++;
            #1;
            start = (mid_start && cyc == 20);
            if (hold > 0) begin
                chk("bp_hold", {resp_valid, pattern, resp_pattern}, {1'b1, 5'd5, 5'd5});
                hold--;
                if (hold == 0) resp_ready = 1'b1;
            end else if (bp && !bp_done && resp_valid && resp_pattern == 5'd5) begin
                resp_ready = 1'b0;
                hold = 3;
                bp_done = 1;
            end
        end
        start = 1'b0;
        if (cyc >= 500) chk("timeout", 0, 1);
        if (!bp) chk("done_latency", cyc, 64);
        else chk("bp_seen", {31'h0, bp_done}, 1);
        chk("signature", signature, exp_sig);
        chk("ones_count", ones_count, exp_ones);
        chk("done_state", {busy, resp_valid, pattern}, {1'b0, 1'b0, 5'd31});
        repeat (3) @(posedge CK);
        #1 chk("done_hold", {done, signature, ones_count}, {1'b1, exp_sig, 6'(exp_ones)});
        chk("records_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] loop_sig;
        int guard;
        loop_sig = misr_of(0);
        repeat (2) @(posedge CK);
        #1 reset = 1'b0;
        chk("reset_state", {resp_valid, busy, done, pattern, resp_pattern, resp_bits, signature, ones_count},
            {3'b000, 5'd0, 5'd0, 1'b0, 16'h0, 6'd0});

        sweep(0, 0, 1, loop_sig, 16);
        sweep(1, 0, 0, 16'h0000, 0);
        sweep(2, 0, 0, 16'h0001, 1);
        sweep(0, 1, 0, loop_sig, 16);
        sweep(0, 0, 0, loop_sig, 16);

        mode = 0;
        for (int p = 0; p < 32; p++) exp_q.push_back({resp_of(0, p), 5'(p)});
        pulse_start();
        guard = 0;
        while (pattern != 5'd10 && guard < 200) begin
            @(posedge CK);
            #1 guard++;
        end
        chk("reach_10", {31'h0, guard < 200}, 1);
        reset = 1'b1;
        @(posedge CK);
        #1 reset = 1'b0;
        exp_q.delete();
        chk("mid_reset", {pattern, busy, resp_valid, done, signature, ones_count},
            {5'd0, 3'b000, 16'h0, 6'd0});
        sweep(0, 0, 0, loop_sig, 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/exhaustive_pattern_driver.md
Name: exhaustive_pattern_driver

Overview:
Upstream stimulus stage for the benchmark trojan-detection flow. It sweeps an N_WIDTH-bit input bus through every value 0..2^N_WIDTH-1 into a combinational/sequential benchmark DUT and waits a programmable settle time per pattern. It then samples the DUT response and hands each (pattern, response) pair to a downstream logger through a valid/ready handshake. It also compacts all responses into a MISR signature and a ones-count, so the sweep result can be compared without reading the full log.

Parameters:
N_WIDTH, 5, width of the DUT input bus; sweep length is 2^N_WIDTH patterns
OUT_WIDTH, 1, width of the DUT response bus (must be <= SIG_WIDTH)
SETTLE_CYCLES, 1, cycles the pattern is held before sampling (legal range 1..255)
SIG_WIDTH, 16, MISR width
SIG_POLY, 16'h1021, MISR feedback polynomial (Galois form, x^SIG_WIDTH term implicit)

Ports:
CK  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE
pattern  out  N_WIDTH  stimulus driven to the DUT
dut_resp  in  OUT_WIDTH  DUT response
resp_valid  out  1  response record available
resp_ready  in  1  logger accepts the record
resp_pattern  out  N_WIDTH  pattern that produced resp_bits
resp_bits  out  OUT_WIDTH  sampled response
busy  out  1  sweep in progress
done  out  1  sweep complete; held until start or reset
signature  out  SIG_WIDTH  MISR value
ones_count  out  N_WIDTH+1  number of patterns with dut_resp[0]==1

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high. Ports are named CK and reset.
- Reset: state=IDLE. pattern, resp_pattern, resp_bits, signature, ones_count, settle counter = 0. resp_valid, busy, done = 0. Reset asserted mid-sweep aborts the sweep the next edge with the same values; there is no partial flush.
- States: IDLE, SETTLE, EMIT, DONE.
- IDLE: on start, go to SETTLE. pattern=0, settle counter=SETTLE_CYCLES-1, signature=0, ones_count=0, busy=1.
- SETTLE: pattern held stable. When the counter is 0, on that edge:
  - sample dut_resp into resp_bits and copy pattern into resp_pattern;
  - update the MISR: sig <= (sig<<1) ^ (sig[MSB] ? SIG_POLY : 0) ^ zero-extended dut_resp;
  - ones_count += dut_resp[0];
  - set resp_valid=1 and go to EMIT.
  Otherwise decrement the counter.
- EMIT: resp_valid=1. pattern, resp_pattern and resp_bits are held stable until resp_valid&&resp_ready. On the handshake edge resp_valid=0, then:
  - if pattern == all-ones: go to DONE, busy=0, done=1. pattern holds all-ones; no wrap-around.
  - else: pattern+1, reload the counter, go to SETTLE.
- DONE: done=1 and signature/ones_count are held. start clears done, restarts at pattern 0 and clears signature/ones_count.
- start in SETTLE/EMIT is ignored.
- MISR and ones_count are updated exactly once per pattern, regardless of backpressure duration.
- Latency: with resp_ready tied high, each pattern takes SETTLE_CYCLES+1 cycles. Start-to-done = 2^N_WIDTH*(SETTLE_CYCLES+1) cycles (64 at defaults).
- ones_count does not saturate; its width covers the maximum value 2^N_WIDTH.

Decomposition:
- Package epd_pkg holds:
  - the state enum (IDLE, SETTLE, EMIT, DONE);
  - default SIG_POLY constant;
  - localparam for the last pattern (all-ones of N_WIDTH).
- One sub-module, resp_misr: parameterised SIG_WIDTH/SIG_POLY/OUT_WIDTH. Inputs: clear, enable, data. Output: signature. The top instantiates it and drives enable with the SETTLE->EMIT transition.
- Sweep FSM, settle counter and ones_count stay in the top.

Test Plan:
- Loopback dut_resp=pattern[0], resp_ready=1, defaults, start at cycle 0 -> 32 records with resp_pattern 0..31 in order, resp_bits alternating 0,1. done rises exactly 64 cycles after start; ones_count=16.
- dut_resp tied 0 -> signature=16'h0000, ones_count=0, done after 64 cycles.
- dut_resp=1 only when pattern==31, else 0 -> signature=16'h0001, ones_count=1.
- resp_ready low for 3 cycles while resp_pattern=5 -> resp_valid stays 1 and pattern/resp_pattern stay 5 for 4 cycles. Record accepted once; ones_count and signature match the ready-high run.
- Reset pulsed while pattern=10 -> next cycle pattern=0, busy=0, resp_valid=0, signature=0. Later start sweeps cleanly from 0.
- start pulsed mid-sweep -> no effect. start pulsed in DONE -> done=0, busy=1, pattern=0, ones_count=0, and a second identical sweep reproduces the same signature.
